// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundle of instruction-memory, redirect/halt and decode handshake signals.
// master: fetch unit side (drives imem_*, inst_valid/data/pc, fetch_err).
// slave : environment side (drives imem_rdata, redirect_*, halt_req, inst_ready).
interface fetch_unit_if;
    logic        imem_rw;
    logic        imem_wren;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_err;

    modport master (
        output imem_rw, imem_wren, imem_addr, inst_valid, inst_data, inst_pc, fetch_err,
        input  imem_rdata, redirect_valid, redirect_pc, halt_req, inst_ready
    );

    modport slave (
        input  imem_rw, imem_wren, imem_addr, inst_valid, inst_data, inst_pc, fetch_err,
        output imem_rdata, redirect_valid, redirect_pc, halt_req, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: program counter + fetch stage feeding a small instruction buffer to decode.
// Ports: clk, rst_n (async, active-low), bus (fetch_unit_if.master):
//   imem_rw/imem_wren tied low, imem_addr = fetch_pc, imem_rdata captured same cycle;
//   redirect_valid/redirect_pc flush and retarget; halt_req blocks new fetches;
//   inst_valid/inst_ready/inst_data/inst_pc decode handshake; fetch_err sticky.
// Optional: define FETCH_ALIGN_CHECK_EN to trap misaligned redirects into ERR.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {RUN, HALTED, ERR} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          err;
    logic          pop;
    logic          push;
    logic          take_redir;
    logic          misalign;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = |bus.redirect_pc[1:0];
`else
    assign misalign = 1'b0;
`endif

    assign take_redir = bus.redirect_valid && state != ERR;
    assign pop        = count != '0 && bus.inst_ready;
    // a pop frees the slot the push writes into, so full+pop still accepts a word
    assign push       = state == RUN && (count != FULL || pop) && !bus.redirect_valid;

    assign bus.imem_rw    = 1'b0;
    assign bus.imem_wren  = 1'b0;
    assign bus.imem_addr  = fetch_pc;
    assign bus.inst_valid = count != '0;
    assign bus.inst_data  = mem_data[rd_ptr];
    assign bus.inst_pc    = mem_pc[rd_ptr];
    assign bus.fetch_err  = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            err      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_data[i] <= '0;
            end
        end else if (take_redir) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (misalign) begin
                state <= ERR;
                err   <= 1'b1;
            end else begin
                fetch_pc <= bus.redirect_pc & ~32'h3;
                state    <= (state == HALTED && !bus.halt_req) ? RUN : state;
            end
        end else begin
            if (push) begin
                mem_pc[wr_ptr]   <= fetch_pc;
                mem_data[wr_ptr] <= bus.imem_rdata;
                wr_ptr           <= wr_ptr + AW'(1);
                fetch_pc         <= fetch_pc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            state <= (state == RUN && bus.halt_req) ? HALTED :
                     (state == HALTED && !bus.halt_req) ? RUN : state;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    fetch_unit_if bus ();

    fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // instruction memory model: word at A is A ^ 32'hA5A5_0000
    assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic do_reset(input logic rdy);
        rst_n = 1'b0;
        bus.inst_ready = rdy;
        bus.halt_req = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.inst_ready = 1'b0;
        bus.halt_req = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        #2;
        total++; if (bus.inst_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.inst_valid); else passed++;
        total++; if (bus.imem_addr !== 32'h0) $display("FAIL reset_addr got %h exp 0", bus.imem_addr); else passed++;
        total++; if (bus.inst_data !== 32'h0) $display("FAIL reset_data got %h exp 0", bus.inst_data); else passed++;
        total++; if (bus.inst_pc !== 32'h0) $display("FAIL reset_pc got %h exp 0", bus.inst_pc); else passed++;
        total++; if (bus.fetch_err !== 1'b0) $display("FAIL reset_err got %b exp 0", bus.fetch_err); else passed++;
        total++; if (bus.imem_rw !== 1'b0 || bus.imem_wren !== 1'b0) $display("FAIL reset_rw got %b%b exp 00", bus.imem_rw, bus.imem_wren); else passed++;
    endtask

    task automatic test_sequential();
        do_reset(1'b1);
        total++; if (bus.inst_valid !== 1'b0) $display("FAIL seq_first_cycle got %b exp 0", bus.inst_valid); else passed++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4*i)) $display("FAIL seq_pc%0d got %b/%h exp 1/%h", i, bus.inst_valid, bus.inst_pc, 32'(4*i)); else passed++;
            total++; if (bus.inst_data !== word(32'(4*i))) $display("FAIL seq_data%0d got %h exp %h", i, bus.inst_data, word(32'(4*i))); else passed++;
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        repeat (5) @(negedge clk);
        total++; if (bus.imem_addr !== 32'h8) $display("FAIL bp_hold_addr got %h exp 8", bus.imem_addr); else passed++;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4*i)) $display("FAIL bp_pc%0d got %b/%h exp 1/%h", i, bus.inst_valid, bus.inst_pc, 32'(4*i)); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        total++; if (bus.inst_pc !== 32'h8) $display("FAIL redir_pre_pc got %h exp 8", bus.inst_pc); else passed++;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h100;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        total++; if (bus.inst_valid !== 1'b0) $display("FAIL redir_flush got %b exp 0", bus.inst_valid); else passed++;
        total++; if (bus.imem_addr !== 32'h100) $display("FAIL redir_addr got %h exp 100", bus.imem_addr); else passed++;
        @(negedge clk);
        total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100) $display("FAIL redir_pc0 got %b/%h exp 1/100", bus.inst_valid, bus.inst_pc); else passed++;
        total++; if (bus.inst_data !== word(32'h100)) $display("FAIL redir_data0 got %h exp %h", bus.inst_data, word(32'h100)); else passed++;
        @(negedge clk);
        total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h104) $display("FAIL redir_pc1 got %b/%h exp 1/104", bus.inst_valid, bus.inst_pc); else passed++;
    endtask

    task automatic test_halt();
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        bus.halt_req = 1'b1;
        @(negedge clk);
        total++; if (bus.imem_addr !== 32'h8 || bus.inst_pc !== 32'h0) $display("FAIL halt_full got %h/%h exp 8/0", bus.imem_addr, bus.inst_pc); else passed++;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h4) $display("FAIL halt_drain got %b/%h exp 1/4", bus.inst_valid, bus.inst_pc); else passed++;
        @(negedge clk);
        total++; if (bus.inst_valid !== 1'b0) $display("FAIL halt_empty got %b exp 0", bus.inst_valid); else passed++;
        @(negedge clk);
        total++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h8) $display("FAIL halt_frozen got %b/%h exp 0/8", bus.inst_valid, bus.imem_addr); else passed++;
        bus.halt_req = 1'b0;
        @(negedge clk);
        total++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h8) $display("FAIL halt_resume_wait got %b/%h exp 0/8", bus.inst_valid, bus.imem_addr); else passed++;
        @(negedge clk);
        total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h8) $display("FAIL halt_resume0 got %b/%h exp 1/8", bus.inst_valid, bus.inst_pc); else passed++;
        @(negedge clk);
        total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'hC) $display("FAIL halt_resume1 got %b/%h exp 1/c", bus.inst_valid, bus.inst_pc); else passed++;
    endtask

    task automatic test_wrap_reset();
        do_reset(1'b1);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        total++; if (bus.imem_addr !== 32'hFFFF_FFF8) $display("FAIL wrap_addr got %h exp fffffff8", bus.imem_addr); else passed++;
        @(negedge clk);
        total++; if (bus.inst_pc !== 32'hFFFF_FFF8) $display("FAIL wrap_pc0 got %h exp fffffff8", bus.inst_pc); else passed++;
        @(negedge clk);
        total++; if (bus.inst_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc1 got %h exp fffffffc", bus.inst_pc); else passed++;
        @(negedge clk);
        total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) $display("FAIL wrap_pc2 got %b/%h exp 1/0", bus.inst_valid, bus.inst_pc); else passed++;
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (bus.inst_valid !== 1'b0) $display("FAIL async_valid got %b exp 0", bus.inst_valid); else passed++;
        total++; if (bus.imem_addr !== 32'h0) $display("FAIL async_addr got %h exp 0", bus.imem_addr); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_align();
        do_reset(1'b1);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h102;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.fetch_err !== 1'b1 || bus.inst_valid !== 1'b0) $display("FAIL align_err%0d got %b/%b exp 1/0", i, bus.fetch_err, bus.inst_valid); else passed++;
            @(negedge clk);
        end
`else
        total++; if (bus.imem_addr !== 32'h100 || bus.fetch_err !== 1'b0) $display("FAIL align_addr got %h/%b exp 100/0", bus.imem_addr, bus.fetch_err); else passed++;
        @(negedge clk);
        total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100) $display("FAIL align_pc got %b/%h exp 1/100", bus.inst_valid, bus.inst_pc); else passed++;
        total++; if (bus.fetch_err !== 1'b0) $display("FAIL align_noerr got %b exp 0", bus.fetch_err); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap_reset();
        test_align();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
